// File: rtl/serial_tx_if.sv
// serial_tx_if: handshake and serial-line bundle for serial_tx.
// The master side (datapath) offers a word with load and watches ready/busy/done;
// the slave side (the transmitter) owns ready, busy, tx and done.
interface serial_tx_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             busy;
  logic             tx;
  logic             done;

  modport master (
    output data_in,
    output load,
    input  ready,
    input  busy,
    input  tx,
    input  done
  );

  modport slave (
    input  data_in,
    input  load,
    output ready,
    output busy,
    output tx,
    output done
  );

endinterface

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// Frame on tx: start bit (0), WIDTH data bits LSB first, optional even parity bit,
// stop bit (1). Every bit is held for BIT_CYCLES clocks. All state changes on the
// falling edge of clk; reset is synchronous and active-low.
// Optional feature macro: SERIAL_TX_PARITY_EN inserts an even-parity bit before stop.
module serial_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic      clk,
  input  logic      reset,
  serial_tx_if.slave bus
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nxt;
  logic [IW-1:0]    bit_idx;
  logic [CW-1:0]    cyc;
  logic             tx_q;
  logic             done_q;
  logic             bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic             parity_q;
`endif

  assign shift_nxt = shift_q >> 1;
  assign bit_end   = (cyc == CYC_LAST);

  // Handshake flags come straight from the state so a load is accepted in the done cycle.
  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state != IDLE);
  assign bus.tx    = tx_q;
  assign bus.done  = done_q;

  // Frame sequencer: state, counters, shift register and registered line outputs.
  always_ff @(negedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      shift_q  <= '0;
      bit_idx  <= '0;
      cyc      <= '0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          cyc  <= '0;
          if (bus.load) begin
            shift_q  <= bus.data_in;
            bit_idx  <= '0;
            state    <= START;
            tx_q     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= ^bus.data_in;
`endif
          end
        end

        START: begin
          if (bit_end) begin
            cyc     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            cyc <= cyc + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            cyc     <= '0;
            shift_q <= shift_nxt;
            if (bit_idx == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
              state <= PARITY;
              tx_q  <= parity_q;
`else
              state <= STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_q    <= shift_nxt[0];
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end

`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cyc   <= '0;
            state <= STOP;
            tx_q  <= 1'b1;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            cyc    <= '0;
            state  <= IDLE;
            tx_q   <= 1'b1;
            done_q <= 1'b1;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
          cyc   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: self-checking bench for serial_tx.
// Two instances: BIT_CYCLES=4 (main) and BIT_CYCLES=1. The DUT updates on the
// falling edge; the bench drives inputs and samples outputs on the rising edge.
// Expected line bits are pushed to a queue when a load is driven and popped as
// the frame is observed. Build with SERIAL_TX_PARITY_EN to cover the parity frame.
module tb_serial_tx;

  localparam int WIDTH = 8;
  localparam int BC    = 4;
  localparam int BC1   = 1;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 3;
`else
  localparam int FRAME_BITS = WIDTH + 2;
`endif

  logic clk;
  logic reset;

  serial_tx_if #(.WIDTH(WIDTH)) bus0 ();
  serial_tx_if #(.WIDTH(WIDTH)) bus1 ();

  serial_tx #(.WIDTH(WIDTH), .BIT_CYCLES(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  serial_tx #(.WIDTH(WIDTH), .BIT_CYCLES(BC1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q[$];

  // Free-running clock; DUT acts on falling edges at 10, 20, 30 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line sequence for one frame: start, data LSB first, [parity], stop.
  task automatic push_frame(input logic [WIDTH-1:0] w);
    exp_q.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(w[i]);
`ifdef SERIAL_TX_PARITY_EN
    exp_q.push_back(^w);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Reset held for three edges with load asserted; line must stay idle afterwards.
  task automatic test_reset();
    reset        = 1'b0;
    bus0.load    = 1'b1;
    bus0.data_in = 8'hFF;
    bus1.load    = 1'b0;
    bus1.data_in = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      n_checks++;
      if ({bus0.tx, bus0.ready, bus0.busy, bus0.done} !== 4'b1100) begin
        n_fail++;
        $display("[TB] FAIL reset_hold[%0d]: tx/ready/busy/done got %b expected 1100", i,
                 {bus0.tx, bus0.ready, bus0.busy, bus0.done});
      end
    end
    n_checks++;
    if ({bus1.tx, bus1.ready, bus1.busy, bus1.done} !== 4'b1100) begin
      n_fail++;
      $display("[TB] FAIL reset_dut1: tx/ready/busy/done got %b expected 1100",
               {bus1.tx, bus1.ready, bus1.busy, bus1.done});
    end
    reset     = 1'b1;
    bus0.load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      n_checks++;
      if ({bus0.tx, bus0.ready, bus0.busy, bus0.done} !== 4'b1100) begin
        n_fail++;
        $display("[TB] FAIL reset_release[%0d]: tx/ready/busy/done got %b expected 1100", i,
                 {bus0.tx, bus0.ready, bus0.busy, bus0.done});
      end
    end
  endtask

  // One frame of 0xA5 checked bit by bit, then a single done pulse.
  task automatic test_basic_frame(input logic [WIDTH-1:0] w, input string tag);
    logic b;
    bus0.data_in = w;
    bus0.load    = 1'b1;
    push_frame(w);
    for (int i = 0; i < FRAME_BITS; i++) begin
      b = exp_q.pop_front();
      for (int c = 0; c < BC; c++) begin
        @(posedge clk);
        bus0.load = 1'b0;
        n_checks++;
        if ({bus0.tx, bus0.busy, bus0.done} !== {b, 1'b1, 1'b0}) begin
          n_fail++;
          $display("[TB] FAIL %s_bit%0d_c%0d: tx/busy/done got %b expected %b", tag, i, c,
                   {bus0.tx, bus0.busy, bus0.done}, {b, 2'b10});
        end
      end
    end
    @(posedge clk);
    n_checks++;
    if ({bus0.done, bus0.ready, bus0.tx} !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL %s_done: done/ready/tx got %b expected 111", tag,
               {bus0.done, bus0.ready, bus0.tx});
    end
    @(posedge clk);
    n_checks++;
    if ({bus0.done, bus0.ready, bus0.tx} !== 3'b011) begin
      n_fail++;
      $display("[TB] FAIL %s_after: done/ready/tx got %b expected 011", tag,
               {bus0.done, bus0.ready, bus0.tx});
    end
  endtask

`ifdef SERIAL_TX_PARITY_EN
  // 0x07 has odd weight, so the even-parity bit is 1 (0xA5 above gives 0).
  task automatic test_parity();
    test_basic_frame(8'h07, "parity07");
  endtask
`endif

  // Second load in the done cycle must start immediately with no idle-high bit.
  task automatic test_back_to_back();
    logic b;
    bus0.data_in = 8'hA5;
    bus0.load    = 1'b1;
    push_frame(8'hA5);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FRAME_BITS; i++) begin
        b = exp_q.pop_front();
        for (int c = 0; c < BC; c++) begin
          @(posedge clk);
          bus0.load = 1'b0;
          n_checks++;
          if ({bus0.tx, bus0.busy, bus0.done} !== {b, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL b2b_f%0d_bit%0d_c%0d: tx/busy/done got %b expected %b", f, i, c,
                     {bus0.tx, bus0.busy, bus0.done}, {b, 2'b10});
          end
        end
      end
      @(posedge clk);
      n_checks++;
      if ({bus0.done, bus0.ready} !== 2'b11) begin
        n_fail++;
        $display("[TB] FAIL b2b_done%0d: done/ready got %b expected 11", f,
                 {bus0.done, bus0.ready});
      end
      if (f == 0) begin
        bus0.data_in = 8'h3C;
        bus0.load    = 1'b1;
        push_frame(8'h3C);
      end
    end
    @(posedge clk);
    n_checks++;
    if ({bus0.done, bus0.tx} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL b2b_after: done/tx got %b expected 01", {bus0.done, bus0.tx});
    end
  endtask

  // Load pulse and data_in churn while busy must not disturb the frame or queue another.
  task automatic test_ignored_load();
    logic b;
    int   k;
    k = 0;
    bus0.data_in = 8'hA5;
    bus0.load    = 1'b1;
    push_frame(8'hA5);
    for (int i = 0; i < FRAME_BITS; i++) begin
      b = exp_q.pop_front();
      for (int c = 0; c < BC; c++) begin
        @(posedge clk);
        k++;
        if (k == 9) begin
          bus0.load    = 1'b1;
          bus0.data_in = 8'h00;
        end else begin
          bus0.load    = 1'b0;
          bus0.data_in = 8'($urandom);
        end
        n_checks++;
        if ({bus0.tx, bus0.busy} !== {b, 1'b1}) begin
          n_fail++;
          $display("[TB] FAIL ign_bit%0d_c%0d: tx/busy got %b expected %b", i, c,
                   {bus0.tx, bus0.busy}, {b, 1'b1});
        end
      end
    end
    @(posedge clk);
    n_checks++;
    if (bus0.done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ign_done: done got %b expected 1", bus0.done);
    end
    for (int i = 0; i < 2 * FRAME_BITS * BC; i++) begin
      @(posedge clk);
      n_checks++;
      if ({bus0.tx, bus0.ready, bus0.done} !== 3'b110) begin
        n_fail++;
        $display("[TB] FAIL ign_idle[%0d]: tx/ready/done got %b expected 110", i,
                 {bus0.tx, bus0.ready, bus0.done});
      end
    end
  endtask

  // Reset in the middle of data bit 3 aborts silently; the next frame is clean.
  task automatic test_abort();
    logic b;
    bus0.data_in = 8'hA5;
    bus0.load    = 1'b1;
    push_frame(8'hA5);
    for (int i = 0; i < 5; i++) begin
      b = exp_q.pop_front();
      for (int c = 0; c < ((i < 4) ? BC : 2); c++) begin
        @(posedge clk);
        bus0.load = 1'b0;
        n_checks++;
        if (bus0.tx !== b) begin
          n_fail++;
          $display("[TB] FAIL abort_pre_bit%0d_c%0d: tx got %b expected %b", i, c, bus0.tx, b);
        end
      end
    end
    exp_q.delete();
    reset = 1'b0;
    @(posedge clk);
    reset = 1'b1;
    n_checks++;
    if ({bus0.tx, bus0.ready, bus0.busy, bus0.done} !== 4'b1100) begin
      n_fail++;
      $display("[TB] FAIL abort_edge: tx/ready/busy/done got %b expected 1100",
               {bus0.tx, bus0.ready, bus0.busy, bus0.done});
    end
    for (int i = 0; i < FRAME_BITS * BC + 4; i++) begin
      @(posedge clk);
      n_checks++;
      if ({bus0.tx, bus0.ready, bus0.done} !== 3'b110) begin
        n_fail++;
        $display("[TB] FAIL abort_idle[%0d]: tx/ready/done got %b expected 110", i,
                 {bus0.tx, bus0.ready, bus0.done});
      end
    end
    test_basic_frame(8'h3C, "abort_next");
  endtask

  // BIT_CYCLES=1 instance: one clock per bit, 0x81 framed.
  task automatic test_bit_cycles_one();
    logic b;
    bus1.data_in = 8'h81;
    bus1.load    = 1'b1;
    push_frame(8'h81);
    for (int i = 0; i < FRAME_BITS; i++) begin
      b = exp_q.pop_front();
      @(posedge clk);
      bus1.load = 1'b0;
      n_checks++;
      if ({bus1.tx, bus1.busy, bus1.done} !== {b, 1'b1, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL bc1_bit%0d: tx/busy/done got %b expected %b", i,
                 {bus1.tx, bus1.busy, bus1.done}, {b, 2'b10});
      end
    end
    @(posedge clk);
    n_checks++;
    if ({bus1.done, bus1.ready, bus1.tx} !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL bc1_done: done/ready/tx got %b expected 111",
               {bus1.done, bus1.ready, bus1.tx});
    end
    @(posedge clk);
    n_checks++;
    if (bus1.done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bc1_after: done got %b expected 0", bus1.done);
    end
  endtask

  // Run every scenario in order and print the summary.
  initial begin
    test_reset();
    test_basic_frame(8'hA5, "basicA5");
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_ignored_load();
    test_abort();
    test_bit_cycles_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
